// File: rtl/riscv_bist_pkg.sv
// March C- BIST types: controller states, march elements and the per-element pattern table.
package riscv_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    RD   = 3'd2,
    CMP  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } bist_state_e;

  typedef enum logic [2:0] {
    ELEM_E0 = 3'd0,
    ELEM_E1 = 3'd1,
    ELEM_E2 = 3'd2,
    ELEM_E3 = 3'd3,
    ELEM_E4 = 3'd4,
    ELEM_E5 = 3'd5
  } march_elem_e;

  typedef struct packed {
    logic up;      // address order: 1 = ascending, 0 = descending
    logic rd_one;  // expected read data is all-ones
    logic wr_one;  // write data is all-ones
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(input march_elem_e e);
    case (e)
      ELEM_E0: return elem_cfg_t'{1'b1, 1'b0, 1'b0};
      ELEM_E1: return elem_cfg_t'{1'b1, 1'b0, 1'b1};
      ELEM_E2: return elem_cfg_t'{1'b1, 1'b1, 1'b0};
      ELEM_E3: return elem_cfg_t'{1'b0, 1'b0, 1'b1};
      ELEM_E4: return elem_cfg_t'{1'b0, 1'b1, 1'b0};
      default: return elem_cfg_t'{1'b1, 1'b0, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/riscv_bist_addr_gen.sv
// Bounded up/down test-address counter over 0..2^(ADDR_WIDTH-1)-2; saturates at either end.
// Latency: address updates one cycle after load/step; at_end is combinational on the current address.
module riscv_bist_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_up,
  input  logic                  step,
  input  logic                  dir_up,
  output logic [ADDR_WIDTH-2:0] addr,
  output logic                  at_end
);

  // Highest tested index: all-ones is x0 and is never issued.
  localparam logic [ADDR_WIDTH-2:0] LAST = {{(ADDR_WIDTH-2){1'b1}}, 1'b0};
  localparam logic [ADDR_WIDTH-2:0] ONE  = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

  assign at_end = dir_up ? (addr == LAST) : (addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_up ? '0 : LAST;
    end else if (step && !at_end) begin
      addr <= dir_up ? addr + ONE : addr - ONE;
    end
  end

endmodule

// File: rtl/riscv_regfile_bist_ctrl.sv
// March C- BIST controller for the register-file test port; captures the first miscompare.
// Read data is checked in the cycle after each read; a passing run is 15N busy cycles.
module riscv_regfile_bist_ctrl
  import riscv_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  input  logic [DATA_WIDTH-1:0] Q_T
);

  bist_state_e           state;
  march_elem_e           elem;
  march_elem_e           elem_next;
  elem_cfg_t             cfg;
  elem_cfg_t             cfg_next;
  logic [ADDR_WIDTH-2:0] addr;
  logic                  at_end;
  logic                  ag_load;
  logic                  ag_load_up;
  logic                  ag_step;
  logic [DATA_WIDTH-1:0] expected;
  logic                  miscmp;

  assign elem_next = march_elem_e'(elem + 3'd1);
  assign cfg       = elem_cfg(elem);
  assign cfg_next  = elem_cfg(elem_next);
  assign expected  = {DATA_WIDTH{cfg.rd_one}};
  assign miscmp    = (Q_T != expected);
  assign A_T       = {1'b0, addr};

  // Counter moves after the last cycle of each address and reloads at element boundaries.
  always_comb begin
    ag_load    = 1'b0;
    ag_load_up = 1'b1;
    ag_step    = 1'b0;
    case (state)
      IDLE, DONE: ag_load = start_i;
      W0: begin
        ag_load = at_end;
        ag_step = !at_end;
      end
      CMP: ag_step = (elem == ELEM_E5) && !miscmp && !at_end;
      WR: begin
        ag_load    = at_end;
        ag_load_up = cfg_next.up;
        ag_step    = !at_end;
      end
      default: ;
    endcase
  end

  riscv_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (ag_load),
    .load_up (ag_load_up),
    .step    (ag_step),
    .dir_up  (cfg.up),
    .addr    (addr),
    .at_end  (at_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      elem        <= ELEM_E0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      fail_data_o <= '0;
      BIST        <= 1'b0;
      CSN_T       <= 1'b1;
      WEN_T       <= 1'b1;
      D_T         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state       <= W0;
            elem        <= ELEM_E0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            fail_data_o <= '0;
            BIST        <= 1'b1;
            CSN_T       <= 1'b0;
            WEN_T       <= 1'b0;
            D_T         <= '0;
          end
        end
        W0: begin
          if (at_end) begin
            state <= RD;
            elem  <= ELEM_E1;
            WEN_T <= 1'b1;
          end
        end
        RD: begin
          state <= CMP;
          CSN_T <= 1'b1;
          WEN_T <= 1'b1;
        end
        CMP: begin
          if (miscmp) begin
            state       <= DONE;
            fail_o      <= 1'b1;
            fail_addr_o <= A_T;
            fail_elem_o <= elem;
            fail_data_o <= Q_T;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            BIST        <= 1'b0;
          end else if (elem == ELEM_E5) begin
            if (at_end) begin
              state  <= DONE;
              pass_o <= 1'b1;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              BIST   <= 1'b0;
            end else begin
              state <= RD;
              CSN_T <= 1'b0;
            end
          end else begin
            state <= WR;
            CSN_T <= 1'b0;
            WEN_T <= 1'b0;
            D_T   <= {DATA_WIDTH{cfg.wr_one}};
          end
        end
        WR: begin
          state <= RD;
          WEN_T <= 1'b1;
          if (at_end) elem <= elem_next;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          BIST   <= 1'b0;
          CSN_T  <= 1'b1;
          WEN_T  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_regfile_bist_ctrl.sv
// Directed bench: register-file model with injectable stuck-at faults around the BIST controller.
module tb_riscv_regfile_bist_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          busy_o, done_o, pass_o, fail_o;
  logic [AW-1:0] fail_addr_o;
  logic [2:0]    fail_elem_o;
  logic [DW-1:0] fail_data_o;
  logic          BIST, CSN_T, WEN_T;
  logic [AW-1:0] A_T;
  logic [DW-1:0] D_T;
  logic [DW-1:0] Q_T = '0;

  int checks = 0;
  int failures = 0;
  int addr_viol = 0;
  int n;

  logic [DW-1:0] mem [0:31];
  logic [AW-1:0] flt_addr = '0;
  logic [DW-1:0] sa1 = '0;
  logic [DW-1:0] sa0 = '0;

  riscv_regfile_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o), .fail_data_o(fail_data_o),
    .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .Q_T(Q_T)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input logic [AW-1:0] a);
    return (a == flt_addr) ? ((v | sa1) & ~sa0) : v;
  endfunction

  // Register file: synchronous write, read data appears the cycle after the read.
  always @(posedge clk) begin
    if (!CSN_T && !WEN_T) mem[A_T] <= D_T;
    if (!CSN_T && WEN_T) Q_T <= faulty(mem[A_T], A_T);
    if (!CSN_T && (A_T[3:0] == 4'hF || A_T[4])) addr_viol <= addr_viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_pass"}, pass_o, 1'b0);
    chk({tag, "_fail"}, fail_o, 1'b0);
    chk({tag, "_faddr"}, fail_addr_o, 5'd0);
    chk({tag, "_felem"}, fail_elem_o, 3'd0);
    chk({tag, "_fdata"}, fail_data_o, 32'd0);
    chk({tag, "_bist"}, BIST, 1'b0);
    chk({tag, "_csn"}, CSN_T, 1'b1);
    chk({tag, "_wen"}, WEN_T, 1'b1);
    chk({tag, "_at"}, A_T, 5'd0);
    chk({tag, "_dt"}, D_T, 32'd0);
  endtask

  // Pulse start, verify the verdict registers clear, then count busy cycles.
  task automatic run(input string tag, input int stray_start_at, input int abort_at,
                     output int cnt);
    cnt = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "_start_busy"}, busy_o, 1'b1);
    chk({tag, "_start_bist"}, BIST, 1'b1);
    chk({tag, "_start_done"}, done_o, 1'b0);
    chk({tag, "_start_pass"}, pass_o, 1'b0);
    chk({tag, "_start_fail"}, fail_o, 1'b0);
    chk({tag, "_start_faddr"}, fail_addr_o, 5'd0);
    chk({tag, "_start_felem"}, fail_elem_o, 3'd0);
    chk({tag, "_start_fdata"}, fail_data_o, 32'd0);
    while (busy_o === 1'b1 && cnt < 2000) begin
      cnt++;
      if (cnt == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        break;
      end
      start_i = (cnt == stray_start_at);
      tick();
    end
    start_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst = 1'b1;
    start_i = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    chk("idle_csn", CSN_T, 1'b1);

    // Clean run with a stray start mid-test; also the address monitor.
    run("clean1", 50, 0, n);
    chk("clean1_len", n, 225);
    chk("clean1_done", done_o, 1'b1);
    chk("clean1_pass", pass_o, 1'b1);
    chk("clean1_fail", fail_o, 1'b0);
    chk("clean1_bist", BIST, 1'b0);
    chk("clean1_csn", CSN_T, 1'b1);
    chk("addr_monitor", addr_viol, 0);
    chk("mem_final", mem[7], 32'd0);

    // Stuck-at-1 on bit 3 of address 5: caught by the first read of E1.
    flt_addr = 5'd5;
    sa1 = 32'h0000_0008;
    sa0 = '0;
    run("sa1", 0, 0, n);
    chk("sa1_len", n, 32);
    chk("sa1_done", done_o, 1'b1);
    chk("sa1_fail", fail_o, 1'b1);
    chk("sa1_pass", pass_o, 1'b0);
    chk("sa1_elem", fail_elem_o, 3'd1);
    chk("sa1_addr", fail_addr_o, 5'd5);
    chk("sa1_data", fail_data_o, 32'h0000_0008);

    // Stuck-at-0 on bit 31 of address 14: caught in E2 (15 + 45 + 14*3 + 2 busy cycles).
    flt_addr = 5'd14;
    sa1 = '0;
    sa0 = 32'h8000_0000;
    run("sa0", 0, 0, n);
    chk("sa0_len", n, 104);
    chk("sa0_fail", fail_o, 1'b1);
    chk("sa0_pass", pass_o, 1'b0);
    chk("sa0_elem", fail_elem_o, 3'd2);
    chk("sa0_addr", fail_addr_o, 5'd14);
    chk("sa0_data", fail_data_o, 32'h7FFF_FFFF);

    // Reset in the middle of a run, then a clean rerun.
    sa0 = '0;
    run("abort", 0, 100, n);
    chk("abort_at", n, 100);
    check_reset("abort");
    run("clean2", 0, 0, n);
    chk("clean2_len", n, 225);
    chk("clean2_done", done_o, 1'b1);
    chk("clean2_pass", pass_o, 1'b1);
    chk("clean2_fail", fail_o, 1'b0);
    chk("addr_monitor2", addr_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
